// File: rtl/pixel_word_packer_if.sv
// pixel_word_packer_if: FIFO read side and DDR write port of the packer.
// master = packer (pops FIFO, issues writes); slave = FIFO/memory side.
interface pixel_word_packer_if #(
  parameter int ADDR_W = 24
);
  logic [23:0]       fifo_dout;
  logic              fifo_empty;
  logic              fifo_valid;
  logic              fifo_rd_en;
  logic [127:0]      wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_req;
  logic              wr_ack;

  modport master (
    input  fifo_dout, fifo_empty, fifo_valid, wr_ack,
    output fifo_rd_en, wr_data, wr_addr, wr_req
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_valid, wr_ack,
    input  fifo_rd_en, wr_data, wr_addr, wr_req
  );
endinterface

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: pops 24-bit pixels, packs 5 per 128-bit DDR word,
// writes words at sequential addresses, flags end_of_write after NUM_FRAMES.
// Ports: clk, reset (async high), bus (pixel_word_packer_if.master:
//   fifo_dout/empty/valid/rd_en, wr_data/addr/req/ack),
//   end_of_write (sticky), frame_idx (frame being written).
// Macro PACK_PIXEL_TAG_EN: wr_data[127:120] = pixel count of the word.
module pixel_word_packer #(
  parameter int PIXELS_PER_FRAME = 786432,
  parameter int NUM_FRAMES       = 1,
  parameter int ADDR_W           = 24,
  parameter int ADDR_STEP        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  pixel_word_packer_if.master        bus,
  output logic                       end_of_write,
  output logic [7:0]                 frame_idx
);

  localparam int PW = $clog2(PIXELS_PER_FRAME + 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(PIXELS_PER_FRAME - 1);
  localparam logic [PW-1:0] FRM_PIX  = PW'(PIXELS_PER_FRAME);

  typedef enum logic [1:0] {FILL, WRITE, DONE} state_t;

  state_t            state_q;
  logic              rd_pend_q;
  logic [2:0]        slot_q;
  logic [119:0]      data_q;
  logic [PW-1:0]     pix_q;
  logic [7:0]        frame_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              eow_q;

  logic              cap;
  logic              ack;
  logic              last_pix;
  logic              frame_end;
  logic [7:0]        nxt_frame;

  // Single outstanding read: a new pop only once the last one returned.
  assign bus.fifo_rd_en = !reset && (state_q == FILL) &&
                          !bus.fifo_empty && !rd_pend_q;

  assign cap       = (state_q == FILL) && rd_pend_q && bus.fifo_valid;
  assign ack       = (state_q == WRITE) && req_q && bus.wr_ack;
  assign last_pix  = (pix_q == LAST_PIX);
  // pix_q reaches the frame size once the frame's last pixel is captured
  assign frame_end = (pix_q == FRM_PIX);
  assign nxt_frame = frame_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      rd_pend_q <= 1'b0;
      slot_q    <= '0;
      data_q    <= '0;
      pix_q     <= '0;
      frame_q   <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      eow_q     <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (bus.fifo_rd_en) rd_pend_q <= 1'b1;
          if (cap) begin
            rd_pend_q <= 1'b0;
            // slots are zero here, so OR-in places the pixel in slot_q
            data_q <= data_q |
                      ({bus.fifo_dout, 96'b0} >> (24 * slot_q));
            slot_q <= slot_q + 3'd1;
            pix_q  <= pix_q + PW'(1);
            if (slot_q == 3'd4 || last_pix) begin
              state_q <= WRITE;
              req_q   <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (ack) begin
            req_q   <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(ADDR_STEP);
            slot_q  <= '0;
            data_q  <= '0;
            state_q <= FILL;
            if (frame_end) begin
              pix_q   <= '0;
              frame_q <= nxt_frame;
              if (32'(nxt_frame) == NUM_FRAMES) begin
                state_q <= DONE;
                eow_q   <= 1'b1;
              end
            end
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= FILL;
      endcase
    end
  end

`ifdef PACK_PIXEL_TAG_EN
  // slot_q holds the word's pixel count while the word is presented
  assign bus.wr_data = {5'b0, slot_q, data_q};
`else
  assign bus.wr_data = {8'h00, data_q};
`endif
  assign bus.wr_addr   = addr_q;
  assign bus.wr_req    = req_q;
  assign end_of_write  = eow_q;
  assign frame_idx     = frame_q;

endmodule
